operand_scoreboard: RTL and testbench
=====================================

# operand_scoreboard

Parametrised register scoreboard that replaces per-stage register-number compare forwarding in the decode stage. It tracks every architectural destination (GPRs plus HI/LO as extra indices) with an outstanding write, and recognises results arriving on any of NWB writeback/bypass ports. For each of NRD source operands it returns ready/forward-select, and it produces a single issue stall. It sits between decode and issue, is clocked, and holds per-register pending/owner state plus sticky error and stall-statistics counters.

## Interface
- NREG, 34, tracked registers; index 0 is hardwired zero, 32 = HI, 33 = LO.
- NRD, 3, source read ports per issued instruction.
- NWB, 3, writeback/bypass ports.
- AW, $clog2(NREG), register index width (derived).
- SW, $clog2(NWB), owner-port field width (derived; minimum 1).
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode presents an instruction.
- src  in  NRD×AW  source register indices.
- src_used  in  NRD  per-port "operand needed" mask.
- dst  in  AW  destination index; 0 = no write.
- dst_port  in  SW  writeback port that will deliver the result.
- wb_valid  in  NWB  writeback port j carries a result this cycle.
- wb_dst  in  NWB×AW  destination of writeback port j.
- flush  in  1  kill all in-flight producers (exception/eret).
- src_ready  out  NRD  operand i is available this cycle.
- src_fwd  out  NRD×(SW+1)  0 = register file, j+1 = bypass from wb port j.
- stall  out  1  issue must hold.
- issue_fire  out  1  instruction accepted this cycle.
- err  out  1  sticky protocol error.
- stall_cnt  out  32  saturating count of stalled cycles.

## Operation
- State per index r≥1: pending[r], owner[r] (SW bits). Index 0 is never pending.
- Operand i ready when: !src_used[i], or src[i]==0, or !pending[src[i]] (fwd=0), or wb_valid[owner]&&wb_dst[owner]==src[i] (fwd=owner+1). The check uses the pre-update state.
- WAW: stall if dst!=0 and pending[dst] without a matching writeback this cycle.
- stall = issue_valid && (any operand not ready || WAW) && !flush.
- issue_fire = issue_valid && !stall && !flush.
- On issue_fire with dst!=0: pending[dst]←1, owner[dst]←dst_port.
- On wb_valid[j] with wb_dst[j]!=0 and owner==j: pending←0.
- Issue set and writeback clear on the same index in the same cycle: the set wins and the new owner is recorded.
- flush: every pending bit cleared next edge; writebacks and issue that cycle are ignored.
- err set (sticky until reset) when:
  - a writeback hits a non-pending nonzero index or a wrong owner (unless flush is active);
  - two wb ports carry the same nonzero wb_dst in one cycle;
  - dst_port≥NWB on issue_fire.
- stall_cnt increments on every cycle stall=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (resetn low, async): pending all 0, owner 0, err 0, stall_cnt 0. Combinational outputs then depend only on inputs: src_ready all 1, src_fwd 0, stall 0, issue_fire = issue_valid && !flush.
- Outputs src_ready/src_fwd/stall/issue_fire are combinational from current state + inputs (zero latency); state visible one cycle after issue_fire.
- Dependent instruction back-to-back after producer: stalls until the cycle its owner port shows the result, then fires with fwd=owner+1 in that same cycle.
- Reset deasserted mid-stream: scoreboard empty; any earlier producer writeback raises err (upstream must flush across reset).

## Test plan
- Reset, issue dst=5 port 1, next cycle src0=5 -> stall=1, stall_cnt=1; then wb_valid[1], wb_dst=5 -> src_ready[0]=1, src_fwd[0]=2, issue_fire=1; next cycle pending[5]=0, src_fwd=0.
- src0=0, src1=0 with pending everywhere -> src_ready=3'b111, no stall.
- Issue dst=33 (LO) port 2 while wb port 2 clears 33 the same cycle -> pending[33] stays 1, owner 2; madd needing 33 stalls.
- Dst=7 pending, new issue dst=7 -> stall (WAW) until wb 7, fires that cycle, pending[7] remains 1.
- Three regs pending, flush=1 with issue_valid=1 -> issue_fire=0; next cycle all pending 0; a later wb to 7 -> err=1 and stays 1.
- Hold stall 2^32+5 cycles (force counter near max) -> stall_cnt saturates at FFFF_FFFF.

Source files
------------

// File: rtl/operand_scoreboard.sv
// operand_scoreboard: per-register pending/owner scoreboard giving operand ready,
// bypass select and a single issue stall for the decode->issue boundary.  Rev 1.0
`default_nettype none

module operand_scoreboard #(
   parameter int NREG = 34,
   parameter int NRD  = 3,
   parameter int NWB  = 3,
   parameter int AW   = $clog2(NREG),
   parameter int SW   = (NWB > 1) ? $clog2(NWB) : 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   issue_valid,
   input  logic [NRD-1:0][AW-1:0] src,
   input  logic [NRD-1:0]         src_used,
   input  logic [AW-1:0]          dst,
   input  logic [SW-1:0]          dst_port,
   input  logic [NWB-1:0]         wb_valid,
   input  logic [NWB-1:0][AW-1:0] wb_dst,
   input  logic                   flush,
   output logic [NRD-1:0]         src_ready,
   output logic [NRD-1:0][SW:0]   src_fwd,
   output logic                   stall,
   output logic                   issue_fire,
   output logic                   err,
   output logic [31:0]            stall_cnt
);

   localparam int          NIDX   = 2**AW;
   localparam logic [AW:0] NREG_V = (AW+1)'(NREG);
   localparam logic [SW:0] NWB_V  = (SW+1)'(NWB);
   localparam logic [SW:0] ONE    = (SW+1)'(1);

   logic [NREG-1:0] r_pending;
   logic [SW-1:0]   r_owner [NREG];
   logic            r_err;
   logic [31:0]     r_stall_cnt;

   logic [NIDX-1:0] w_pend;
   logic [NIDX-1:0] w_deliv;
   logic [SW-1:0]   w_own [NIDX];
   logic [NWB-1:0]  w_wb_hit;
   logic [NWB-1:0]  w_wb_bad;
   logic            w_dup;
   logic            w_waw;
   logic            w_dst_live;
   logic            w_err_now;

   // Pad state views to the full index space so any AW-bit index is in range.
   for (genvar r = 0; r < NIDX; r++) begin : g_idx
      if (r < NREG) begin : g_live
         assign w_pend[r]  = r_pending[r];
         assign w_own[r]   = r_owner[r];
         assign w_deliv[r] = ({1'b0, r_owner[r]} < NWB_V) && wb_valid[r_owner[r]]
                             && (wb_dst[r_owner[r]] == AW'(r));
      end else begin : g_pad
         assign w_pend[r]  = 1'b0;
         assign w_own[r]   = '0;
         assign w_deliv[r] = 1'b0;
      end
   end

   always_comb begin
      w_wb_hit = '0;
      w_wb_bad = '0;
      w_dup    = 1'b0;
      for (int j = 0; j < NWB; j++) begin
         w_wb_hit[j] = wb_valid[j] && w_pend[wb_dst[j]] && (w_own[wb_dst[j]] == SW'(j));
         w_wb_bad[j] = wb_valid[j] && (wb_dst[j] != '0) && !w_wb_hit[j];
         for (int k = j + 1; k < NWB; k++) begin
            if (wb_valid[j] && wb_valid[k] && (wb_dst[j] != '0) && (wb_dst[j] == wb_dst[k]))
               w_dup = 1'b1;
         end
      end
   end

   always_comb begin
      src_ready = '1;
      src_fwd   = '0;
      for (int i = 0; i < NRD; i++) begin
         if (src_used[i] && w_pend[src[i]]) begin
            src_ready[i] = w_deliv[src[i]];
            src_fwd[i]   = w_deliv[src[i]] ? ({1'b0, w_own[src[i]]} + ONE) : '0;
         end
      end
   end

   assign w_dst_live = (dst != '0) && ({1'b0, dst} < NREG_V);
   assign w_waw      = w_pend[dst] && !w_deliv[dst];
   assign stall      = issue_valid && (!(&src_ready) || w_waw) && !flush;
   assign issue_fire = issue_valid && !stall && !flush;
   assign w_err_now  = ((|w_wb_bad) && !flush) || w_dup
                       || (issue_fire && ({1'b0, dst_port} >= NWB_V));
   assign err        = r_err;
   assign stall_cnt  = r_stall_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pending   <= '0;
         r_err       <= 1'b0;
         r_stall_cnt <= '0;
         for (int r = 0; r < NREG; r++) r_owner[r] <= '0;
      end else begin
         if (flush) begin
            r_pending <= '0;
         end else begin
            for (int j = 0; j < NWB; j++) begin
               if (w_wb_hit[j]) r_pending[wb_dst[j]] <= 1'b0;
            end
            // Later assignment lets a same-cycle issue override the writeback clear.
            if (issue_fire && w_dst_live) begin
               r_pending[dst] <= 1'b1;
               r_owner[dst]   <= dst_port;
            end
         end
         if (w_err_now) r_err <= 1'b1;
         if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_operand_scoreboard.sv
// tb_operand_scoreboard: directed vectors with hand-computed expectations.  Rev 1.0
`default_nettype none

module tb_operand_scoreboard;

   localparam int NRD = 3;
   localparam int NWB = 3;
   localparam int AW  = 6;
   localparam int SW  = 2;

   logic                   clk    = 1'b0;
   logic                   resetn = 1'b0;
   logic                   issue_valid;
   logic [NRD-1:0][AW-1:0] src;
   logic [NRD-1:0]         src_used;
   logic [AW-1:0]          dst;
   logic [SW-1:0]          dst_port;
   logic [NWB-1:0]         wb_valid;
   logic [NWB-1:0][AW-1:0] wb_dst;
   logic                   flush;
   logic [NRD-1:0]         src_ready;
   logic [NRD-1:0][SW:0]   src_fwd;
   logic                   stall;
   logic                   issue_fire;
   logic                   err;
   logic [31:0]            stall_cnt;

   int vectors     = 0;
   int miscompares = 0;

   operand_scoreboard dut (
      .clk(clk), .resetn(resetn), .issue_valid(issue_valid), .src(src),
      .src_used(src_used), .dst(dst), .dst_port(dst_port), .wb_valid(wb_valid),
      .wb_dst(wb_dst), .flush(flush), .src_ready(src_ready), .src_fwd(src_fwd),
      .stall(stall), .issue_fire(issue_fire), .err(err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      issue_valid = 1'b0; flush = 1'b0; src = '0; src_used = '0;
      dst = '0; dst_port = '0; wb_valid = '0; wb_dst = '0;
   endtask

   task automatic issue(input logic [AW-1:0] d, input logic [SW-1:0] p);
      idle(); issue_valid = 1'b1; dst = d; dst_port = p;
   endtask

   initial begin
      idle();
      // Reset state: outputs depend only on inputs
      @(negedge clk); issue_valid = 1'b1; #1;
      chk("rst_ready", src_ready, 3'b111);
      chk("rst_fwd", src_fwd, 9'd0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_fire", issue_fire, 1'b1);
      chk("rst_err", err, 1'b0);
      chk("rst_cnt", stall_cnt, 32'd0);
      flush = 1'b1; #1;
      chk("rst_fire_flush", issue_fire, 1'b0);
      @(negedge clk); idle(); resetn = 1'b1;

      // Producer dst=5 on port 1, dependent stalls, then forwards from port 1
      @(negedge clk); issue(6'd5, 2'd1); #1;
      chk("t1_prod_fire", issue_fire, 1'b1);
      @(negedge clk); idle(); issue_valid = 1'b1; src[0] = 6'd5; src_used = 3'b001; #1;
      chk("t1_stall", stall, 1'b1);
      chk("t1_ready_wait", src_ready, 3'b110);
      chk("t1_fire_wait", issue_fire, 1'b0);
      @(negedge clk); idle(); issue_valid = 1'b1; src[0] = 6'd5; src_used = 3'b001;
      wb_valid = 3'b010; wb_dst[1] = 6'd5; #1;
      chk("t1_cnt", stall_cnt, 32'd1);
      chk("t1_ready_byp", src_ready, 3'b111);
      chk("t1_fwd_byp", src_fwd, 9'd2);
      chk("t1_fire_byp", issue_fire, 1'b1);
      @(negedge clk); idle(); issue_valid = 1'b1; src[0] = 6'd5; src_used = 3'b001; #1;
      chk("t1_fwd_rf", src_fwd, 9'd0);
      chk("t1_fire_rf", issue_fire, 1'b1);
      chk("t1_err", err, 1'b0);

      // Zero and unused sources are always ready
      @(negedge clk); issue(6'd1, 2'd0);
      @(negedge clk); issue(6'd2, 2'd1);
      @(negedge clk); issue(6'd3, 2'd2);
      @(negedge clk); idle(); issue_valid = 1'b1; src = {6'd3, 6'd0, 6'd0}; src_used = 3'b011; #1;
      chk("t2_zero_ready", src_ready, 3'b111);
      chk("t2_zero_stall", stall, 1'b0);
      @(negedge clk); idle(); issue_valid = 1'b1; src = {6'd3, 6'd2, 6'd1}; src_used = 3'b111;
      wb_valid = 3'b001; wb_dst[0] = 6'd1; #1;
      chk("t2_mix_ready", src_ready, 3'b001);
      chk("t2_mix_fwd", src_fwd, 9'd1);
      chk("t2_mix_stall", stall, 1'b1);
      @(negedge clk); idle(); wb_valid = 3'b110; wb_dst[1] = 6'd2; wb_dst[2] = 6'd3; #1;
      chk("t2_cnt", stall_cnt, 32'd2);
      @(negedge clk); idle(); issue_valid = 1'b1; src = {6'd3, 6'd2, 6'd1}; src_used = 3'b111; #1;
      chk("t2_all_clear", src_ready, 3'b111);
      chk("t2_err", err, 1'b0);

      // LO (33): re-issue in the same cycle its writeback arrives keeps it pending
      @(negedge clk); issue(6'd33, 2'd2); #1;
      chk("t3_fire1", issue_fire, 1'b1);
      @(negedge clk); issue(6'd33, 2'd2); wb_valid = 3'b100; wb_dst[2] = 6'd33; #1;
      chk("t3_fire2", issue_fire, 1'b1);
      @(negedge clk); idle(); issue_valid = 1'b1; src = {6'd0, 6'd32, 6'd33}; src_used = 3'b011; #1;
      chk("t3_madd_ready", src_ready, 3'b110);
      chk("t3_madd_stall", stall, 1'b1);
      @(negedge clk); idle(); issue_valid = 1'b1; src = {6'd0, 6'd32, 6'd33}; src_used = 3'b011;
      wb_valid = 3'b100; wb_dst[2] = 6'd33; #1;
      chk("t3_madd_fwd", src_fwd, 9'd3);
      chk("t3_madd_fire", issue_fire, 1'b1);
      chk("t3_cnt", stall_cnt, 32'd3);

      // WAW on 7: stall until the writeback, then the new owner (port 1) holds it
      @(negedge clk); issue(6'd7, 2'd0);
      @(negedge clk); issue(6'd7, 2'd1); #1;
      chk("t4_waw_stall", stall, 1'b1);
      chk("t4_waw_fire", issue_fire, 1'b0);
      @(negedge clk); issue(6'd7, 2'd1); wb_valid = 3'b001; wb_dst[0] = 6'd7; #1;
      chk("t4_waw_release", issue_fire, 1'b1);
      @(negedge clk); idle(); issue_valid = 1'b1; src[0] = 6'd7; src_used = 3'b001; #1;
      chk("t4_still_pending", stall, 1'b1);
      @(negedge clk); idle(); issue_valid = 1'b1; src[0] = 6'd7; src_used = 3'b001;
      wb_valid = 3'b010; wb_dst[1] = 6'd7; #1;
      chk("t4_new_owner_fwd", src_fwd, 9'd2);
      chk("t4_cnt", stall_cnt, 32'd5);
      chk("t4_err", err, 1'b0);

      // Flush kills in-flight producers; a stale writeback then raises err
      @(negedge clk); issue(6'd7, 2'd0);
      @(negedge clk); issue(6'd8, 2'd1);
      @(negedge clk); issue(6'd9, 2'd2);
      @(negedge clk); issue(6'd10, 2'd0); flush = 1'b1; src[0] = 6'd7; src_used = 3'b001; #1;
      chk("t5_flush_fire", issue_fire, 1'b0);
      chk("t5_flush_stall", stall, 1'b0);
      @(negedge clk); idle(); issue_valid = 1'b1; src = {6'd9, 6'd8, 6'd7}; src_used = 3'b111; #1;
      chk("t5_post_ready", src_ready, 3'b111);
      chk("t5_post_fire", issue_fire, 1'b1);
      @(negedge clk); idle(); wb_valid = 3'b001; wb_dst[0] = 6'd7; #1;
      chk("t5_err_before", err, 1'b0);
      @(negedge clk); idle(); #1;
      chk("t5_err_set", err, 1'b1);
      @(negedge clk); idle(); #1;
      chk("t5_err_sticky", err, 1'b1);

      // Asynchronous reset mid-cycle clears err and the counter immediately
      @(negedge clk); idle(); resetn = 1'b0; #1;
      chk("t6_async_err", err, 1'b0);
      chk("t6_async_cnt", stall_cnt, 32'd0);
      @(negedge clk); resetn = 1'b1;

      // Issue naming a non-existent writeback port
      @(negedge clk); issue(6'd6, 2'd3); #1;
      chk("t7_badport_fire", issue_fire, 1'b1);
      @(negedge clk); idle(); #1;
      chk("t7_badport_err", err, 1'b1);
      @(negedge clk); idle(); resetn = 1'b0;
      @(negedge clk); resetn = 1'b1;

      // Stall counter saturation, starting from a preloaded near-max value
      @(negedge clk); issue(6'd5, 2'd0);
      @(negedge clk); idle(); issue_valid = 1'b1; src[0] = 6'd5; src_used = 3'b001; #1;
      dut.r_stall_cnt = 32'hFFFF_FFFD;
      @(negedge clk); #1;
      chk("t8_cnt_fe", stall_cnt, 32'hFFFF_FFFE);
      @(negedge clk); #1;
      chk("t8_cnt_ff", stall_cnt, 32'hFFFF_FFFF);
      @(negedge clk); #1;
      chk("t8_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
      chk("t8_stall_held", stall, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
